// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator with a main/skid output buffer and valid/ready on both sides.
// Optional 16-bit compressed decode is enabled by defining IMM_GEN_RVC_EN.
module imm_gen_pipe #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned TAG_W       = 32,
  parameter bit          SYS_CSR_IMM = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [6:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned FMT_W = 7;

  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_FENCE    = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_OP32     = 7'b0111011;

  localparam logic [FMT_W-1:0] FMT_R   = 7'b0000001;
  localparam logic [FMT_W-1:0] FMT_I   = 7'b0000010;
  localparam logic [FMT_W-1:0] FMT_S   = 7'b0000100;
  localparam logic [FMT_W-1:0] FMT_B   = 7'b0001000;
  localparam logic [FMT_W-1:0] FMT_J   = 7'b0010000;
  localparam logic [FMT_W-1:0] FMT_U   = 7'b0100000;
  localparam logic [FMT_W-1:0] FMT_SYS = 7'b1000000;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [FMT_W-1:0] fmt;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } entry_t;

  logic [XLEN-1:0]  dec_imm_c;
  logic [FMT_W-1:0] dec_fmt_c;
  logic             dec_ill_c;
  entry_t           new_c;

  entry_t main_q, main_d, skid_q, skid_d;
  logic   main_valid_q, main_valid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   in_ready_q, in_ready_d;
  logic   accept_c, deliver_c;

  // Immediate extraction from the incoming word.
  always_comb begin : decode
    dec_imm_c = '0;
    dec_fmt_c = '0;
    dec_ill_c = 1'b0;
    if (in_instr[1:0] == 2'b11) begin
      case (in_instr[6:0])
        OPC_OP: dec_fmt_c = FMT_R;
        OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
          dec_imm_c = XLEN'($signed(in_instr[31:20]));
          dec_fmt_c = FMT_I;
        end
        OPC_STORE: begin
          dec_imm_c = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
          dec_fmt_c = FMT_S;
        end
        OPC_BRANCH: begin
          dec_imm_c = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                     in_instr[11:8], 1'b0}));
          dec_fmt_c = FMT_B;
        end
        OPC_JAL: begin
          dec_imm_c = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                     in_instr[30:21], 1'b0}));
          dec_fmt_c = FMT_J;
        end
        OPC_LUI, OPC_AUIPC: begin
          dec_imm_c = XLEN'($signed({in_instr[31:12], 12'b0}));
          dec_fmt_c = FMT_U;
        end
        OPC_FENCE: dec_fmt_c = '0;
        OPC_SYSTEM: begin
          if (SYS_CSR_IMM) dec_imm_c = XLEN'(in_instr[31:20]);
          dec_fmt_c = FMT_SYS;
        end
        OPC_OP_IMM32: begin
          if (XLEN == 64) begin
            dec_imm_c = XLEN'($signed(in_instr[31:20]));
            dec_fmt_c = FMT_I;
          end else begin
            dec_ill_c = 1'b1;
          end
        end
        OPC_OP32: begin
          if (XLEN == 64) dec_fmt_c = FMT_R;
          else            dec_ill_c = 1'b1;
        end
        default: dec_ill_c = 1'b1;
      endcase
    end else begin
`ifdef IMM_GEN_RVC_EN
      // Compressed word: quadrant plus funct3 selects the encoding.
      case ({in_instr[1:0], in_instr[15:13]})
        5'b01_000, 5'b01_010: begin
          dec_imm_c = XLEN'($signed({in_instr[12], in_instr[6:2]}));
          dec_fmt_c = FMT_I;
        end
        5'b01_011: begin
          if (in_instr[11:7] == 5'd2) begin
            dec_ill_c = 1'b1;
          end else begin
            dec_imm_c = XLEN'($signed({in_instr[12], in_instr[6:2], 12'b0}));
            dec_fmt_c = FMT_U;
          end
        end
        5'b01_101: begin
          dec_imm_c = XLEN'($signed({in_instr[12], in_instr[8], in_instr[10:9], in_instr[6],
                                     in_instr[7], in_instr[2], in_instr[11], in_instr[5:3],
                                     1'b0}));
          dec_fmt_c = FMT_J;
        end
        5'b01_110, 5'b01_111: begin
          dec_imm_c = XLEN'($signed({in_instr[12], in_instr[6:5], in_instr[2],
                                     in_instr[11:10], in_instr[4:3], 1'b0}));
          dec_fmt_c = FMT_B;
        end
        5'b00_010: begin
          dec_imm_c = XLEN'({in_instr[5], in_instr[12:10], in_instr[6], 2'b00});
          dec_fmt_c = FMT_I;
        end
        5'b00_110: begin
          dec_imm_c = XLEN'({in_instr[5], in_instr[12:10], in_instr[6], 2'b00});
          dec_fmt_c = FMT_S;
        end
        default: dec_ill_c = 1'b1;
      endcase
`else
      dec_ill_c = 1'b1;
`endif
    end
  end

  always_comb begin : pack_entry
    new_c.imm     = dec_imm_c;
    new_c.fmt     = dec_fmt_c;
    new_c.illegal = dec_ill_c;
    new_c.tag     = in_tag;
  end

  assign accept_c  = in_valid && in_ready_q && !flush;
  assign deliver_c = main_valid_q && out_ready;

  // Main/skid buffer update; skid is only ever full while main is full.
  always_comb begin : next_state
    main_d       = main_q;
    main_valid_d = main_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || deliver_c) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = accept_c;
        if (accept_c) skid_d = new_c;
      end else begin
        main_valid_d = accept_c;
        if (accept_c) main_d = new_c;
      end
    end else if (accept_c) begin
      skid_d       = new_c;
      skid_valid_d = 1'b1;
    end
    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk) begin : regs
    if (rst) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  // Held low while rst is asserted so nothing is offered during reset.
  assign in_ready    = in_ready_q && !rst;
  assign out_valid   = main_valid_q;
  assign out_imm     = main_q.imm;
  assign out_fmt     = main_q.fmt;
  assign out_illegal = main_q.illegal;
  assign out_tag     = main_q.tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share one input stream
// and are checked against an arithmetic reference model and an occupancy-queue scoreboard.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_tag;

  logic        in_ready, out_valid, out_illegal;
  logic [31:0] out_imm, out_tag;
  logic [6:0]  out_fmt;

  logic        in_ready64, out_valid64, out_illegal64;
  logic [63:0] out_imm64;
  logic [31:0] out_tag64;
  logic [6:0]  out_fmt64;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(32), .SYS_CSR_IMM(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm), .out_fmt(out_fmt),
    .out_illegal(out_illegal), .out_tag(out_tag)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(32), .SYS_CSR_IMM(1'b1)) dut64 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready64), .in_instr(in_instr), .in_tag(in_tag),
    .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64), .out_fmt(out_fmt64),
    .out_illegal(out_illegal64), .out_tag(out_tag64)
  );

  typedef struct {
    logic [31:0] imm32;
    logic [6:0]  fmt32;
    logic        ill32;
    logic [63:0] imm64;
    logic [6:0]  fmt64;
    logic        ill64;
    logic [31:0] tag;
  } exp_t;

  exp_t exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic longint sx(input longint v, input int bits);
    return (v >= (longint'(1) << (bits - 1))) ? v - (longint'(1) << bits) : v;
  endfunction

  // Reference: field positions taken from the ISA encoding, assembled arithmetically.
  function automatic void ref_dec(input logic [31:0] ins, input bit x64,
                                  output logic [63:0] imm, output logic [6:0] fmt,
                                  output logic ill);
    longint u = longint'(ins);
    longint v = 0;
    fmt = 7'd0;
    ill = 1'b0;
    if ((u & 3) == 3) begin
      case (u & 127)
        longint'(7'h33): fmt = 7'b0000001;
        longint'(7'h13), longint'(7'h03), longint'(7'h67): begin
          v = sx(u >> 20, 12); fmt = 7'b0000010;
        end
        longint'(7'h23): begin
          v = sx((u >> 25) * 32 + ((u >> 7) & 31), 12); fmt = 7'b0000100;
        end
        longint'(7'h63): begin
          v = sx(((u >> 31) & 1) * 4096 + ((u >> 7) & 1) * 2048 + ((u >> 25) & 63) * 32
                 + ((u >> 8) & 15) * 2, 13);
          fmt = 7'b0001000;
        end
        longint'(7'h6F): begin
          v = sx((((u >> 31) & 1) << 20) + (((u >> 12) & 255) << 12)
                 + (((u >> 20) & 1) << 11) + (((u >> 21) & 1023) << 1), 21);
          fmt = 7'b0010000;
        end
        longint'(7'h37), longint'(7'h17): begin
          v = sx((u >> 12) << 12, 32); fmt = 7'b0100000;
        end
        longint'(7'h0F): fmt = 7'd0;
        longint'(7'h73): begin
          v = u >> 20; fmt = 7'b1000000;
        end
        longint'(7'h1B): if (x64) begin v = sx(u >> 20, 12); fmt = 7'b0000010; end
                         else ill = 1'b1;
        longint'(7'h3B): if (x64) fmt = 7'b0000001; else ill = 1'b1;
        default: ill = 1'b1;
      endcase
    end else begin
`ifdef IMM_GEN_RVC_EN
      longint q  = u & 3;
      longint f3 = (u >> 13) & 7;
      longint i6 = ((u >> 12) & 1) * 32 + ((u >> 2) & 31);
      if (q == 1 && (f3 == 0 || f3 == 2)) begin
        v = sx(i6, 6); fmt = 7'b0000010;
      end else if (q == 1 && f3 == 3) begin
        if (((u >> 7) & 31) == 2) ill = 1'b1;
        else begin v = sx(i6 << 12, 18); fmt = 7'b0100000; end
      end else if (q == 1 && f3 == 5) begin
        v = sx((((u >> 12) & 1) << 11) + (((u >> 8) & 1) << 10) + (((u >> 9) & 3) << 8)
               + (((u >> 6) & 1) << 7) + (((u >> 7) & 1) << 6) + (((u >> 2) & 1) << 5)
               + (((u >> 11) & 1) << 4) + (((u >> 3) & 7) << 1), 12);
        fmt = 7'b0010000;
      end else if (q == 1 && f3 >= 6) begin
        v = sx((((u >> 12) & 1) << 8) + (((u >> 5) & 3) << 6) + (((u >> 2) & 1) << 5)
               + (((u >> 10) & 3) << 3) + (((u >> 3) & 3) << 1), 9);
        fmt = 7'b0001000;
      end else if (q == 0 && (f3 == 2 || f3 == 6)) begin
        v = (((u >> 5) & 1) << 6) + (((u >> 10) & 7) << 3) + (((u >> 6) & 1) << 2);
        fmt = (f3 == 2) ? 7'b0000010 : 7'b0000100;
      end else begin
        ill = 1'b1;
      end
`else
      ill = 1'b1;
`endif
    end
    if (ill) begin v = 0; fmt = 7'd0; end
    imm = 64'(v);
  endfunction

  task automatic check_outputs();
    chk("in_ready", 64'(in_ready), 64'(exp_q.size() < 2));
    chk("out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
    chk("in_ready64", 64'(in_ready64), 64'(exp_q.size() < 2));
    chk("out_valid64", 64'(out_valid64), 64'(exp_q.size() > 0));
    if (exp_q.size() > 0) begin
      chk("imm32", 64'(out_imm), 64'(exp_q[0].imm32));
      chk("fmt32", 64'(out_fmt), 64'(exp_q[0].fmt32));
      chk("ill32", 64'(out_illegal), 64'(exp_q[0].ill32));
      chk("tag32", 64'(out_tag), 64'(exp_q[0].tag));
      chk("imm64", out_imm64, exp_q[0].imm64);
      chk("fmt64", 64'(out_fmt64), 64'(exp_q[0].fmt64));
      chk("ill64", 64'(out_illegal64), 64'(exp_q[0].ill64));
      chk("tag64", 64'(out_tag64), 64'(exp_q[0].tag));
    end
  endtask

  // One clock: drive inputs, advance the scoreboard on the edge, then check.
  task automatic cyc(input logic v, input logic [31:0] ins, input logic [31:0] tg,
                     input logic ordy, input logic fl);
    logic acc, dlv;
    exp_t e;
    logic [63:0] imm;
    in_valid = v; in_instr = ins; in_tag = tg; out_ready = ordy; flush = fl;
    acc = v && in_ready && !fl;
    dlv = out_valid && ordy;
    @(posedge clk);
    if (fl) begin
      exp_q.delete();
    end else begin
      if (dlv && exp_q.size() > 0) void'(exp_q.pop_front());
      if (acc) begin
        ref_dec(ins, 1'b0, imm, e.fmt32, e.ill32);
        e.imm32 = imm[31:0];
        ref_dec(ins, 1'b1, e.imm64, e.fmt64, e.ill64);
        e.tag = tg;
        exp_q.push_back(e);
      end
    end
    #1;
    check_outputs();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] opcs [13] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h6F,
                              7'h37, 7'h17, 7'h0F, 7'h73, 7'h1B, 7'h3B};
    logic [31:0] w = $urandom;
    int sel = $urandom_range(0, 9);
    if (sel < 7) w[6:0] = opcs[$urandom_range(0, 12)];
    else if (sel == 7) w[1:0] = 2'($urandom_range(0, 2));
    return w;
  endfunction

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_tag = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'(1));
    chk("post_rst_imm", 64'(out_imm), 64'(0));
    chk("post_rst_fmt", 64'(out_fmt), 64'(0));
    chk("post_rst_ill", 64'(out_illegal), 64'(0));
    chk("post_rst_tag", 64'(out_tag), 64'(0));
    check_outputs();

    cyc(1'b1, 32'hFFF00093, 32'h100, 1'b1, 1'b0);
    chk("addi_imm", 64'(out_imm), 64'hFFFF_FFFF);
    chk("addi_fmt", 64'(out_fmt), 64'b0000010);
    chk("addi_tag", 64'(out_tag), 64'h100);
    chk("addi_ill", 64'(out_illegal), 64'(0));

    cyc(1'b1, 32'h123450B7, 32'h104, 1'b1, 1'b0);
    chk("lui_imm", 64'(out_imm), 64'h1234_5000);
    cyc(1'b1, 32'hFFDFF06F, 32'h108, 1'b1, 1'b0);
    chk("jal_imm", 64'(out_imm), 64'hFFFF_FFFC);
    cyc(1'b1, 32'h00000463, 32'h10C, 1'b1, 1'b0);
    chk("beq_imm", 64'(out_imm), 64'h8);
    cyc(1'b1, 32'h0020A623, 32'h110, 1'b1, 1'b0);
    chk("sw_imm", 64'(out_imm), 64'hC);
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Back-pressure: two fill main and skid, the third waits.
    cyc(1'b1, 32'hFFF00093, 32'h200, 1'b0, 1'b0);
    cyc(1'b1, 32'h123450B7, 32'h204, 1'b0, 1'b0);
    chk("stall_in_ready", 64'(in_ready), 64'(0));
    cyc(1'b1, 32'h0020A623, 32'h208, 1'b0, 1'b0);
    chk("stall_hold_imm", 64'(out_imm), 64'hFFFF_FFFF);
    chk("stall_hold_tag", 64'(out_tag), 64'h200);
    cyc(1'b1, 32'h0020A623, 32'h208, 1'b1, 1'b0);
    chk("release_tag", 64'(out_tag), 64'h204);
    cyc(1'b1, 32'h0020A623, 32'h208, 1'b1, 1'b0);
    chk("third_tag", 64'(out_tag), 64'h208);
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Flush with both entries buffered and an input offered.
    cyc(1'b1, 32'hFFF00093, 32'h300, 1'b0, 1'b0);
    cyc(1'b1, 32'h123450B7, 32'h304, 1'b0, 1'b0);
    cyc(1'b1, 32'h00000463, 32'h308, 1'b0, 1'b1);
    chk("flush_out_valid", 64'(out_valid), 64'(0));
    chk("flush_in_ready", 64'(in_ready), 64'(1));
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("flush_no_capture", 64'(out_valid), 64'(0));

    cyc(1'b1, 32'h0000007F, 32'h400, 1'b1, 1'b0);
    chk("illegal_flag", 64'(out_illegal), 64'(1));
    chk("illegal_imm", 64'(out_imm), 64'(0));
    chk("illegal_fmt", 64'(out_fmt), 64'(0));
    cyc(1'b1, 32'h800000B7, 32'h404, 1'b1, 1'b0);
    chk("lui64_imm", out_imm64, 64'hFFFF_FFFF_8000_0000);
    cyc(1'b1, 32'h0000557D, 32'h408, 1'b1, 1'b0);
`ifdef IMM_GEN_RVC_EN
    chk("cli_imm", 64'(out_imm), 64'hFFFF_FFFF);
    chk("cli_fmt", 64'(out_fmt), 64'b0000010);
`else
    chk("cli_illegal", 64'(out_illegal), 64'(1));
`endif

    for (int i = 0; i < 800; i++) begin
      cyc(1'($urandom_range(0, 3) != 0), rand_instr(), $urandom,
          1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 40) == 0));
    end
    for (int i = 0; i < 4; i++) cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
